sample_burst_scheduler: RTL and testbench
=========================================

# sample_burst_scheduler

Round-robin scheduler that shares the single sample path into the fault-detection datapath between four sensor channels. It grants one channel at a time for a burst of BURST samples, which equals the detector's 4-sample averaging window. It forwards each sample with its channel tag through a registered valid/ready output. A channel that stalls mid-burst is aborted after a timeout and flagged with a sticky error bit.

## Interface
- DW, 8, sample width; matches the detector sample input.
- BURST, 4, samples per grant (range 1..7).
- TIMEOUT, 15, idle cycles tolerated mid-burst before abort (range 1..255).
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  4  per-channel sample available; bit i belongs to channel i.
- data_in  in  4*DW  channel i sample on bits [i*DW +: DW].
- ack  out  4  one-hot, 1-cycle pulse: channel's current sample was consumed.
- out_valid  out  1  out_data/out_ch hold a sample.
- out_ready  in  1  downstream accepts the sample when out_valid && out_ready.
- out_data  out  DW  sample value.
- out_ch  out  2  channel tag; drives the detector channel select.
- out_last  out  1  marks the BURST-th sample of a completed burst.
- timeout_err  out  4  sticky per-channel abort flag.
- clr_err  in  1  clears timeout_err on the next edge.
- busy  out  1  high in GRANT state.

## Operation
- States: IDLE and GRANT. Registers:
  - gnt (2 b): channel currently granted.
  - last (2 b): last channel served.
  - cnt (3 b): samples accepted in this burst.
  - wait_cnt (8 b): consecutive stall cycles.
- IDLE:
  - If any req is set, pick the first set bit searching last+1, last+2, … modulo 4.
  - Load gnt, clear cnt and wait_cnt, go to GRANT.
  - If no req is set, stay in IDLE.
- GRANT, output slot free: the slot is free when out_valid is 0 or out_ready is 1.
  - Accept when req[gnt] is 1 and the slot is free.
  - On accept: register data_in[gnt], set out_ch=gnt, assert out_valid, pulse ack[gnt], cnt+1, clear wait_cnt.
  - out_last = (cnt+1 == BURST).
- GRANT, stall: if req[gnt] is 0, increment wait_cnt.
  - If the output slot is occupied (backpressure), wait_cnt holds instead; backpressure never counts as a timeout.
- Burst complete: the cycle cnt reaches BURST, set last=gnt and return to IDLE.
- Timeout: wait_cnt == TIMEOUT triggers an abort.
  - Set timeout_err[gnt], set last=gnt, return to IDLE.
  - Samples already forwarded are not recalled; no out_last is issued for an aborted burst.
- Output register: cleared when out_valid && out_ready and no new accept happens in the same cycle. It is reloaded in that same cycle if a new accept occurs (full throughput).
- Simultaneous events: if clr_err and a new timeout occur in the same cycle, the new timeout bit wins. Other bits clear.
- Request changes: changes on req for non-granted channels have no effect until the next IDLE arbitration.

## Timing
- Reset values:
  - Outputs: ack=0, out_valid=0, out_data=0, out_ch=0, out_last=0, timeout_err=0, busy=0.
  - Internal: state=IDLE, last=3 (channel 0 has first priority), cnt=0, wait_cnt=0.
- Reset mid-burst drops the in-flight sample and partial count immediately (asynchronous).
- Arbitration: 1 cycle (IDLE → GRANT). The first accept can occur in the first GRANT cycle.
- Latency: accept at edge N; out_valid/out_data are visible after edge N; ack[gnt] is high in the cycle before edge N (combinational from state, req and slot-free).
- Throughput: BURST samples in BURST+1 cycles with continuous req and out_ready=1.
- Abort latency: TIMEOUT stall cycles after the last accept (or after grant); timeout_err is set at that edge.

## Structure
- Shared package `fault_pkg`:
  - NCH=4, channel index width 2.
  - State enum {S_IDLE, S_GRANT}.
  - Sample width default 8.
  - Severity codes for the detector, kept together with the channel constants.
- Sub-module `rr_pick4`: combinational 4-way round-robin picker (req, last → valid, idx). It can be reused by future multi-requester blocks.

## Test plan
- Single burst: req=0001, data 10,20,30,40 held steady, out_ready=1.
  - out_ch=0, samples 10,20,30,40 on 4 consecutive cycles.
  - out_last on 40; busy falls after the burst; 5 cycles total.
- Round-robin: req=1111 constant.
  - Bursts ordered ch0, ch1, ch2, ch3, ch0.
  - One IDLE cycle between bursts; 4 acks per channel.
- Backpressure: out_ready=0 for 20 cycles mid-burst of ch2.
  - out_valid and out_data held stable; no new ack; no timeout_err.
  - Burst completes after out_ready returns.
- Timeout: ch1 granted, req[1] drops after 2 samples.
  - After 15 stall cycles timeout_err=0010, return to IDLE, next channel served.
  - clr_err then returns timeout_err to 0000.
- Reset mid-burst: assert reset during the 3rd sample of ch3.
  - All outputs 0 immediately.
  - After release with req=1001, ch0 is served first.
- Collision: clr_err in the same cycle as a ch2 timeout, with timeout_err=0001 beforehand.
  - Result timeout_err=0100.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared constants and types for the fault-detection sample path.
package fault_pkg;

  localparam int unsigned NCH        = 4;
  localparam int unsigned CHW        = 2;
  localparam int unsigned DW_DEFAULT = 8;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  // Severity codes reported by the detector, indexed alongside channel tags.
  typedef enum logic [1:0] {
    SEV_NONE,
    SEV_WARN,
    SEV_FAULT,
    SEV_CRIT
  } severity_t;

  function automatic logic [NCH-1:0] ch_onehot(input logic [CHW-1:0] ch);
    logic [NCH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set request after 'last'.
module rr_pick4
  import fault_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] last,
  output logic           valid,
  output logic [CHW-1:0] idx
);

  logic [CHW-1:0] cand;

  // Walk last+1 .. last+4 (mod 4); the first requesting channel wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = last + CHW'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sample_burst_scheduler.sv
// Round-robin burst scheduler sharing one sample path between four channels,
// with a registered valid/ready output and per-channel stall timeout.
module sample_burst_scheduler
  import fault_pkg::*;
#(
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] data_in,
  output logic [NCH-1:0]    ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CHW-1:0]    out_ch,
  output logic              out_last,
  output logic [NCH-1:0]    timeout_err,
  input  logic              clr_err,
  output logic              busy
);

  state_t         state_q, state_d;
  logic [CHW-1:0] gnt_q;
  logic [CHW-1:0] last_q;
  logic [2:0]     cnt_q;
  logic [7:0]     wait_q;

  logic           pick_valid;
  logic [CHW-1:0] pick_idx;
  logic           slot_free;
  logic           accept;
  logic           stall;
  logic [2:0]     cnt_inc;
  logic           burst_done;
  logic           abort;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Accept/stall decode, next state and the combinational ack pulse.
  always_comb begin
    slot_free  = !out_valid || out_ready;
    accept     = (state_q == S_GRANT) && req[gnt_q] && slot_free;
    stall      = (state_q == S_GRANT) && !req[gnt_q] && slot_free;
    cnt_inc    = cnt_q + 3'd1;
    burst_done = accept && (cnt_inc == 3'(BURST));
    abort      = stall && ((wait_q + 8'd1) == 8'(TIMEOUT));
    ack        = accept ? ch_onehot(gnt_q) : '0;
    busy       = (state_q == S_GRANT);
    state_d    = state_q;
    case (state_q)
      S_IDLE:  if (pick_valid) state_d = S_GRANT;
      S_GRANT: if (burst_done || abort) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant bookkeeping: state, granted channel, priority pointer, counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= CHW'(NCH - 1);
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (pick_valid) begin
          gnt_q  <= pick_idx;
          cnt_q  <= '0;
          wait_q <= '0;
        end
      end else begin
        if (accept) begin
          cnt_q  <= cnt_inc;
          wait_q <= '0;
        end else if (stall) begin
          wait_q <= wait_q + 8'd1;
        end
        if (burst_done || abort) last_q <= gnt_q;
      end
    end
  end

  // Output slot: reload on accept, otherwise empty once downstream takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= data_in[32'(gnt_q) * DW +: DW];
      out_ch    <= gnt_q;
      out_last  <= burst_done;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end
  end

  // Sticky abort flags; a fresh abort survives a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err <= '0;
    end else begin
      timeout_err <= (clr_err ? '0 : timeout_err) | (abort ? ch_onehot(gnt_q) : '0);
    end
  end

endmodule

// File: tb/tb_sample_burst_scheduler.sv
// Directed bench for sample_burst_scheduler with a queue-based output scoreboard.
module tb_sample_burst_scheduler;
  import fault_pkg::*;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [4*DW-1:0] data_in;
  logic [3:0]    ack;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic          out_last;
  logic [3:0]    timeout_err;
  logic          clr_err;
  logic          busy;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned k[4];
  int unsigned ack_cnt[4];

  sample_burst_scheduler #(.DW(DW), .BURST(4), .TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .data_in     (data_in),
    .ack         (ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_last    (out_last),
    .timeout_err (timeout_err),
    .clr_err     (clr_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Sample n of channel c: ch0 gives 10,20,30,...; ch1 60,70,...; ch2 110,...; ch3 160,...
  function automatic logic [7:0] sval(input int unsigned c, input int unsigned n);
    return 8'((c * 50 + 10 * (n + 1)) % 256);
  endfunction

  task automatic drive_data();
    for (int c = 0; c < 4; c++) data_in[c*DW +: DW] = sval(c, k[c]);
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin
      k[c]       = 0;
      ack_cnt[c] = 0;
    end
    drive_data();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d, input logic l);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    e.last = l;
    expq.push_back(e);
  endtask

  task automatic push_burst(input int unsigned c, input int unsigned n0);
    for (int unsigned n = 0; n < 4; n++) push(2'(c), sval(c, n0 + n), n == 3);
  endtask

  // One clock: note ack before the edge, then advance that sensor's sample.
  task automatic step();
    logic [3:0] a;
    @(negedge clk);
    a = ack;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (a[c]) begin
        k[c]++;
        ack_cnt[c]++;
      end
    end
    drive_data();
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    req       = '0;
    clr_err   = 1'b0;
    out_ready = 1'b1;
    clear_counts();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) step();
    check(name, expq.size(), 0);
  endtask

  // Scoreboard monitor: a transfer happens at the next edge when valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got ch=%0d data=%0d last=%0b, expected no output",
                 out_ch, out_data, out_last);
      end else begin
        e = expq.pop_front();
        if ({out_ch, out_data, out_last} !== {e.ch, e.data, e.last}) begin
          errors++;
          $display("FAIL out_sample: got ch=%0d data=%0d last=%0b, expected ch=%0d data=%0d last=%0b",
                   out_ch, out_data, out_last, e.ch, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    reset     = 1'b1;
    req       = '0;
    clr_err   = 1'b0;
    out_ready = 1'b1;
    clear_counts();
    #1;
    check("rst_ack", ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_last", out_last, 0);
    check("rst_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    reset_dut();

    // Single burst on ch0
    req = 4'b0001;
    push_burst(0, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("single_busy", busy, (i != 5));
    end
    req = '0;
    drain("single_drain");
    check("single_acks", ack_cnt[0], 4);

    // Round-robin with all channels requesting
    reset_dut();
    req = 4'b1111;
    push_burst(0, 0);
    push_burst(1, 0);
    push_burst(2, 0);
    push_burst(3, 0);
    push_burst(0, 4);
    for (int i = 1; i <= 25; i++) begin
      step();
      check("rr_busy", busy, (i % 5 != 0));
    end
    req = '0;
    drain("rr_drain");
    check("rr_acks0", ack_cnt[0], 8);
    check("rr_acks1", ack_cnt[1], 4);
    check("rr_acks2", ack_cnt[2], 4);
    check("rr_acks3", ack_cnt[3], 4);

    // Backpressure mid-burst of ch2
    reset_dut();
    req = 4'b0100;
    push_burst(2, 0);
    repeat (3) step();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, sval(2, 1));
      check("bp_noack", ack_cnt[2], 2);
    end
    check("bp_err", timeout_err, 0);
    out_ready = 1'b1;
    repeat (2) step();
    req = '0;
    drain("bp_drain");
    check("bp_acks", ack_cnt[2], 4);
    check("bp_err_end", timeout_err, 0);

    // Timeout on ch1 after two samples, then ch2 is served
    reset_dut();
    req = 4'b0010;
    push(2'd1, sval(1, 0), 1'b0);
    push(2'd1, sval(1, 1), 1'b0);
    repeat (3) step();
    req = 4'b0101;
    push_burst(2, 0);
    repeat (14) step();
    check("to_err_early", timeout_err, 0);
    check("to_busy_early", busy, 1);
    step();
    check("to_err", timeout_err, 4'b0010);
    check("to_busy", busy, 0);
    repeat (5) step();
    req = '0;
    drain("to_drain");
    check("to_acks1", ack_cnt[1], 2);
    check("to_acks2", ack_cnt[2], 4);
    check("to_acks0", ack_cnt[0], 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("to_clr", timeout_err, 0);

    // Asynchronous reset during the third ch3 sample
    reset_dut();
    req = 4'b1000;
    push(2'd3, sval(3, 0), 1'b0);
    repeat (3) step();
    reset = 1'b1;
    #1;
    check("mid_ack", ack, 0);
    check("mid_valid", out_valid, 0);
    check("mid_data", out_data, 0);
    check("mid_ch", out_ch, 0);
    check("mid_last", out_last, 0);
    check("mid_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_counts();
    req = 4'b1001;
    push_burst(0, 0);
    repeat (5) step();
    req = '0;
    drain("mid_drain");
    check("mid_acks0", ack_cnt[0], 4);
    check("mid_acks3", ack_cnt[3], 0);

    // clr_err coinciding with a new ch2 timeout
    reset_dut();
    req = 4'b0001;
    step();
    req = '0;
    repeat (15) step();
    check("col_pre", timeout_err, 4'b0001);
    check("col_pre_busy", busy, 0);
    req = 4'b0100;
    step();
    req = '0;
    repeat (14) step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("col_err", timeout_err, 4'b0100);
    check("col_busy", busy, 0);
    drain("col_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
